// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: issues sequential imem requests under a credit limit and
// buffers returned words with their PCs for in-order delivery to the IF/ID boundary.
module inst_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    input  logic                       stall,
    input  logic                       halt,
    output logic                       imem_req,
    output logic [31:0]                imem_addr,
    input  logic                       imem_rvalid,
    input  logic [31:0]                imem_rdata,
    output logic                       inst_valid,
    output logic [31:0]                inst,
    output logic [31:0]                inst_pc,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned OW = PW + 1;
    // Pending can exceed DEPTH while wrong-path responses are still draining.
    localparam int unsigned CW = PW + 2;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   fetch_pc_r, fetch_pc_n;
    logic [31:0]   resp_pc_r, resp_pc_n;
    logic [31:0]   q_inst_r [DEPTH];
    logic [31:0]   q_pc_r   [DEPTH];
    logic [PW-1:0] wr_ptr_r, wr_ptr_n;
    logic [PW-1:0] rd_ptr_r, rd_ptr_n;
    logic [OW-1:0] occ_r, occ_n;
    logic [CW-1:0] pending_r, pending_n;
    logic [CW-1:0] drop_cnt_r, drop_cnt_n;

    logic [CW-1:0] live_s;
    logic          req_s;
    logic          valid_s;
    logic          pop_s;
    logic          push_s;
    logic          drop_s;
    logic          rsp_dec_s;

    // Credit, handshake and queue-control decodes.
    always_comb begin
        live_s    = {1'b0, occ_r} + pending_r - drop_cnt_r;
        req_s     = rst && !halt && !redirect && (live_s < DEPTH_C);
        valid_s   = (occ_r != {OW{1'b0}});
        pop_s     = valid_s && !stall && !redirect;
        drop_s    = imem_rvalid && (drop_cnt_r != {CW{1'b0}});
        push_s    = imem_rvalid && !redirect && (drop_cnt_r == {CW{1'b0}});
        rsp_dec_s = imem_rvalid && (pending_r != {CW{1'b0}});
    end

    // Next-state computation; redirect overrides every other update.
    always_comb begin
        fetch_pc_n = fetch_pc_r;
        resp_pc_n  = resp_pc_r;
        wr_ptr_n   = wr_ptr_r;
        rd_ptr_n   = rd_ptr_r;
        occ_n      = occ_r;
        pending_n  = pending_r - {{(CW-1){1'b0}}, rsp_dec_s} + {{(CW-1){1'b0}}, req_s};
        drop_cnt_n = drop_cnt_r;
        if (redirect) begin
            fetch_pc_n = redirect_pc;
            resp_pc_n  = redirect_pc;
            wr_ptr_n   = {PW{1'b0}};
            rd_ptr_n   = {PW{1'b0}};
            occ_n      = {OW{1'b0}};
            // Every response still outstanding after this cycle belongs to the old path.
            drop_cnt_n = pending_r - {{(CW-1){1'b0}}, rsp_dec_s};
        end else begin
            fetch_pc_n = req_s  ? fetch_pc_r + 32'd4 : fetch_pc_r;
            resp_pc_n  = push_s ? resp_pc_r + 32'd4  : resp_pc_r;
            wr_ptr_n   = push_s ? wr_ptr_r + {{(PW-1){1'b0}}, 1'b1} : wr_ptr_r;
            rd_ptr_n   = pop_s  ? rd_ptr_r + {{(PW-1){1'b0}}, 1'b1} : rd_ptr_r;
            occ_n      = occ_r + {{(OW-1){1'b0}}, push_s} - {{(OW-1){1'b0}}, pop_s};
            drop_cnt_n = drop_s ? drop_cnt_r - {{(CW-1){1'b0}}, 1'b1} : drop_cnt_r;
        end
    end

    // Control and PC state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_r <= RESET_PC;
            resp_pc_r  <= RESET_PC;
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            occ_r      <= {OW{1'b0}};
            pending_r  <= {CW{1'b0}};
            drop_cnt_r <= {CW{1'b0}};
        end else begin
            fetch_pc_r <= fetch_pc_n;
            resp_pc_r  <= resp_pc_n;
            wr_ptr_r   <= wr_ptr_n;
            rd_ptr_r   <= rd_ptr_n;
            occ_r      <= occ_n;
            pending_r  <= pending_n;
            drop_cnt_r <= drop_cnt_n;
        end
    end

    // Queue storage; a write into the slot being popped at full is safe since the pop reads first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                q_inst_r[i] <= NOP_INST;
                q_pc_r[i]   <= 32'h0000_0000;
            end
        end else if (push_s) begin
            q_inst_r[wr_ptr_r] <= imem_rdata;
            q_pc_r[wr_ptr_r]   <= resp_pc_r;
        end else begin
            q_inst_r[wr_ptr_r] <= q_inst_r[wr_ptr_r];
            q_pc_r[wr_ptr_r]   <= q_pc_r[wr_ptr_r];
        end
    end

    assign imem_req   = req_s;
    assign imem_addr  = fetch_pc_r;
    assign inst_valid = valid_s;
    assign inst       = valid_s ? q_inst_r[rd_ptr_r] : NOP_INST;
    assign inst_pc    = valid_s ? q_pc_r[rd_ptr_r]   : 32'h0000_0000;
    assign occupancy  = occ_r;

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed bench for inst_prefetch_queue with a fixed-latency in-order imem model.
module tb_inst_prefetch_queue;

    localparam logic [31:0] KEY = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        halt;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [2:0]  occupancy;

    int n_vec;
    int n_err;
    int lat;
    logic        slot_v [0:7];
    logic [31:0] slot_a [0:7];

    inst_prefetch_queue dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .halt        (halt),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .occupancy   (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic mem_clear();
        for (int i = 0; i < 8; i++) begin
            slot_v[i] = 1'b0;
            slot_a[i] = 32'h0;
        end
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
    endtask

    // One clock: sample the request, take the edge, then advance the imem pipeline.
    task automatic step();
        logic        r;
        logic [31:0] a;
        #1;
        r = imem_req && rst;
        a = imem_addr;
        @(posedge clk);
        #1;
        for (int i = 0; i < 7; i++) begin
            slot_v[i] = slot_v[i+1];
            slot_a[i] = slot_a[i+1];
        end
        slot_v[7] = 1'b0;
        slot_a[7] = 32'h0;
        if (r) begin
            slot_v[lat-1] = 1'b1;
            slot_a[lat-1] = a;
        end
        imem_rvalid = slot_v[0];
        imem_rdata  = slot_v[0] ? (slot_a[0] ^ KEY) : 32'h0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        mem_clear();
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_vec({tag, "_req"},   32'(imem_req),   32'd0);
        check_vec({tag, "_addr"},  imem_addr,       32'h0);
        check_vec({tag, "_valid"}, 32'(inst_valid), 32'd0);
        check_vec({tag, "_inst"},  inst,            NOP);
        check_vec({tag, "_pc"},    inst_pc,         32'h0);
        check_vec({tag, "_occ"},   32'(occupancy),  32'd0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        lat = 1;
        rst = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        stall = 1'b0;
        halt = 1'b0;
        mem_clear();
        #2;
        check_reset_outputs("rst0");

        // Reset and stream with 1-cycle latency.
        step();
        step();
        rst = 1'b1;
        #1;
        check_vec("s_req0", 32'(imem_req), 32'd1);
        check_vec("s_addr0", imem_addr, 32'h0);
        step();
        check_vec("s_valid_e1", 32'(inst_valid), 32'd0);
        check_vec("s_addr1", imem_addr, 32'h4);
        step();
        check_vec("s_valid_e2", 32'(inst_valid), 32'd1);
        check_vec("s_pc_e2", inst_pc, 32'h0);
        check_vec("s_inst_e2", inst, KEY);
        for (int k = 1; k <= 5; k++) begin
            step();
            check_vec("s_valid", 32'(inst_valid), 32'd1);
            check_vec("s_pc", inst_pc, 32'(4 * k));
            check_vec("s_inst", inst, KEY ^ 32'(4 * k));
            check_vec("s_occ", 32'(occupancy), 32'd1);
            check_vec("s_addr", imem_addr, 32'(4 * (k + 2)));
        end

        // Stall fill and release.
        stall = 1'b1;
        do_reset();
        step();
        step();
        check_vec("f_pc_e2", inst_pc, 32'h0);
        check_vec("f_occ_e2", 32'(occupancy), 32'd1);
        step();
        step();
        step();
        check_vec("f_occ_full", 32'(occupancy), 32'd4);
        check_vec("f_req_full", 32'(imem_req), 32'd0);
        check_vec("f_pc_full", inst_pc, 32'h0);
        step();
        check_vec("f_occ_hold", 32'(occupancy), 32'd4);
        check_vec("f_req_hold", 32'(imem_req), 32'd0);
        check_vec("f_inst_hold", inst, KEY);
        stall = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            check_vec("f_rel_valid", 32'(inst_valid), 32'd1);
            check_vec("f_rel_pc", inst_pc, 32'(4 * k));
        end

        // Push and pop in the same cycle while full.
        stall = 1'b1;
        do_reset();
        for (int k = 0; k < 5; k++) step();
        check_vec("pp_occ_pre", 32'(occupancy), 32'd4);
        stall = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = KEY ^ 32'h10;
        step();
        check_vec("pp_occ", 32'(occupancy), 32'd4);
        check_vec("pp_pc0", inst_pc, 32'h4);
        step();
        check_vec("pp_pc1", inst_pc, 32'h8);
        step();
        check_vec("pp_pc2", inst_pc, 32'hC);
        step();
        check_vec("pp_pc3", inst_pc, 32'h10);
        check_vec("pp_inst3", inst, KEY ^ 32'h10);

        // Redirect with three responses in flight, one landing in the redirect cycle.
        lat = 3;
        stall = 1'b0;
        do_reset();
        step();
        step();
        step();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0100;
        #1;
        check_vec("r_req_redir", 32'(imem_req), 32'd0);
        step();
        redirect = 1'b0;
        #1;
        check_vec("r_req_next", 32'(imem_req), 32'd1);
        check_vec("r_addr_next", imem_addr, 32'h100);
        check_vec("r_occ_next", 32'(occupancy), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check_vec("r_no_stale", 32'(inst_valid), 32'd0);
        end
        step();
        check_vec("r_valid", 32'(inst_valid), 32'd1);
        check_vec("r_pc", inst_pc, 32'h100);
        check_vec("r_inst", inst, KEY ^ 32'h100);
        step();
        check_vec("r_pc2", inst_pc, 32'h104);

        // Halt with two requests outstanding.
        do_reset();
        step();
        step();
        halt = 1'b1;
        #1;
        check_vec("h_req0", 32'(imem_req), 32'd0);
        step();
        check_vec("h_req1", 32'(imem_req), 32'd0);
        check_vec("h_valid1", 32'(inst_valid), 32'd0);
        step();
        check_vec("h_pc_a", inst_pc, 32'h0);
        check_vec("h_req2", 32'(imem_req), 32'd0);
        step();
        check_vec("h_pc_b", inst_pc, 32'h4);
        check_vec("h_inst_b", inst, KEY ^ 32'h4);
        step();
        check_vec("h_valid_empty", 32'(inst_valid), 32'd0);
        check_vec("h_inst_empty", inst, NOP);
        check_vec("h_pc_empty", inst_pc, 32'h0);
        check_vec("h_occ_empty", 32'(occupancy), 32'd0);
        check_vec("h_req3", 32'(imem_req), 32'd0);
        halt = 1'b0;
        #1;
        check_vec("h_resume_req", 32'(imem_req), 32'd1);
        check_vec("h_resume_addr", imem_addr, 32'h8);

        // Build occupancy, then assert reset between clock edges.
        stall = 1'b1;
        for (int k = 0; k < 6; k++) step();
        check_vec("a_occ_pre", 32'(occupancy), 32'd3);
        check_vec("a_pc_pre", inst_pc, 32'h8);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("arst");

        mem_clear();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/inst_prefetch_queue.md
Name: inst_prefetch_queue

Overview:
Front-end fetch block sitting directly upstream of the 5-stage pipeline core. It issues sequential requests to instruction memory and buffers the returned words with their PCs in a small in-order queue. It presents one instruction per cycle to the IF/ID boundary, holds it under stall, discards wrong-path words on branch redirect, and stops fetching on halt.

Parameters:
DEPTH, 4, queue entries (power of two, >=2); also the maximum number of live requests.
RESET_PC, 32'h0000_0000, first fetch address after reset.
NOP_INST, 32'h0000_0013, word driven on inst when the queue is empty (addi x0,x0,0).

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  asynchronous reset, active-low
redirect  in  1  flush the queue and restart fetch at redirect_pc (branch mispredict or jump)
redirect_pc  in  32  new fetch address, word aligned
stall  in  1  consumer cannot accept an instruction this cycle (load-use NOP)
halt  in  1  stop issuing new requests; level sensitive
imem_req  out  1  request strobe; one word per cycle
imem_addr  out  32  request address, valid while imem_req=1
imem_rvalid  in  1  response strobe; responses return in order, latency >=1 cycle
imem_rdata  in  32  response word
inst_valid  out  1  queue head is valid
inst  out  32  head instruction, or NOP_INST when empty
inst_pc  out  32  PC of head, 0 when empty
occupancy  out  log2(DEPTH)+1  number of valid entries

Behaviour:
- Reset (rst=0, asynchronous): fetch_pc=RESET_PC, resp_pc=RESET_PC, queue empty, pending=0, drop_cnt=0. imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=NOP_INST, inst_pc=0, occupancy=0. Fetching starts on the first edge after reset is released. Reset mid-operation abandons all pending responses without a drop count; imem must be reset together with this block.
- Registered state: fetch_pc, resp_pc, circular queue (inst, pc) with wr_ptr/rd_ptr, pending (issued but not yet returned), drop_cnt (pending responses marked wrong-path).
- Credit: live = occupancy + pending - drop_cnt. imem_req = !halt && !redirect && live < DEPTH. imem_addr = fetch_pc. When imem_req=1: fetch_pc += 4 and pending += 1. The queue can never overflow.
- Response (imem_rvalid=1): pending -= 1. If drop_cnt>0, drop_cnt -= 1 and the word is discarded. Otherwise the word is written with pc=resp_pc, and resp_pc += 4.
- Pop: occurs when inst_valid && !stall && !redirect; rd_ptr advances. Push and pop in the same cycle leave occupancy unchanged, including when the queue is full.
- Outputs inst, inst_pc and inst_valid come combinationally from the head entry. Minimum latency from imem_rvalid to inst_valid is 1 cycle.
- Redirect has highest priority:
  - the queue empties at the next edge and any pop that cycle is ignored;
  - fetch_pc and resp_pc are set to redirect_pc;
  - drop_cnt is set to the pending count after this cycle's response (pending - imem_rvalid); a response arriving in the redirect cycle is always discarded;
  - no request is issued in the redirect cycle, and the first request to redirect_pc goes out in the following cycle.
- Back-to-back redirects: the last one wins; drop_cnt is recomputed from current pending each time.
- Halt: new requests stop, but outstanding responses still land and the queue still drains. Deasserting halt resumes at fetch_pc. Redirect during halt updates the PCs but issues nothing.
- Arithmetic: all PC arithmetic is modulo 2^32, so 0xFFFF_FFFC+4 wraps to 0. Pointers wrap modulo DEPTH.

Test Plan:
- Reset and stream: release rst, 1-cycle-latency imem returning addr^32'hA5A5_0000. Required: imem_addr sequence 0,4,8,...; first inst_valid 2 cycles after release with inst_pc=0; then one instruction per cycle with contiguous PCs.
- Stall fill: hold stall=1 from the first valid. Required: occupancy reaches 4 and stays there, imem_req drops to 0, and inst/inst_pc hold at pc 0. Releasing stall yields pcs 0,4,8,12 on consecutive cycles with no gap.
- Redirect with in-flight responses: 3-cycle latency, pending=3, redirect to 0x100 in a cycle that also has rvalid. Required: the next 2 responses are dropped, the first new imem_addr is 0x100 one cycle after redirect, and the first valid inst_pc=0x100.
- Simultaneous push/pop at full: occupancy=4 with rvalid and pop in the same cycle. Required: occupancy stays 4, no entry is lost, and PC order is preserved.
- Halt: assert halt with pending=2. Required: no imem_req, both responses enqueued, queue drains to empty with inst=0x0000_0013 and inst_valid=0. Deasserting halt resumes at the next sequential PC.
- Async reset mid-stream: pull rst low between clock edges. Required: outputs go to reset values immediately, with no wait for the clock edge.
